// File: rtl/csd_pkg.sv
// csd_pkg: shared CSD digit codes and digit type
package csd_pkg;
  typedef logic [1:0] csd_digit_t;
  localparam csd_digit_t CSD_0   = 2'b00;
  localparam csd_digit_t CSD_P1  = 2'b01;
  localparam csd_digit_t CSD_M1  = 2'b10;
  localparam csd_digit_t CSD_ILL = 2'b11;
endpackage

// File: rtl/csd_to_bin_if.sv
// csd_to_bin_if: sample/result bundle between a CSD source and the converter
interface csd_to_bin_if #(parameter int W = 5);
  logic           ena;
  logic [2*W-1:0] x;
  logic [W-1:0]   y;
  logic           y_vld;
  logic           err;
  logic           ovf;
  modport master (output ena, x, input y, y_vld, err, ovf);
  modport slave  (input ena, x, output y, y_vld, err, ovf);
endinterface

// File: rtl/csd_digit_split.sv
// csd_digit_split: decode CSD digits into +1/-1/illegal masks (adjacency mask with CSD_TO_BIN_CANON_CHECK_EN)
module csd_digit_split
  import csd_pkg::*;
#(
  parameter int W = 5
) (
  input  logic [2*W-1:0] x,
  output logic [W-1:0]   p,
  output logic [W-1:0]   n,
`ifdef CSD_TO_BIN_CANON_CHECK_EN
  output logic [W-1:0]   adj,
`endif
  output logic [W-1:0]   ill
);
  for (genvar g = 0; g < W; g++) begin : g_dig
    csd_digit_t d;
    assign d      = x[2*g+1:2*g];
    assign p[g]   = d == CSD_P1;
    assign n[g]   = d == CSD_M1;
    assign ill[g] = d == CSD_ILL;
  end
`ifdef CSD_TO_BIN_CANON_CHECK_EN
  assign adj = (p | n) & ((p | n) >> 1);
`endif
endmodule

// File: rtl/csd_to_bin.sv
// csd_to_bin: registered CSD-to-two's-complement converter with err/ovf flags (optional CSD_TO_BIN_CANON_CHECK_EN)
module csd_to_bin #(
  parameter int W = 5
) (
  input logic        clk,
  input logic        rst,
  csd_to_bin_if.slave bus
);
  logic [W-1:0] p, n, ill;
  logic [W:0]   v;
  logic         bad;
  logic [W-1:0] y_d, y_q;
  logic         y_vld_d, y_vld_q, err_d, err_q, ovf_d, ovf_q;
`ifdef CSD_TO_BIN_CANON_CHECK_EN
  logic [W-1:0] adj;
  csd_digit_split #(.W(W)) u_split (.x(bus.x), .p(p), .n(n), .adj(adj), .ill(ill));
  assign bad = |ill | |adj;
`else
  csd_digit_split #(.W(W)) u_split (.x(bus.x), .p(p), .n(n), .ill(ill));
  assign bad = |ill;
`endif
  assign v = {1'b0, p} - {1'b0, n};
  // next state: reset clears, ena loads a fresh conversion, otherwise hold
  always_comb begin
    y_d     = rst ? '0 : bus.ena ? v[W-1:0] : y_q;
    err_d   = rst ? 1'b0 : bus.ena ? bad : err_q;
    ovf_d   = rst ? 1'b0 : bus.ena ? v[W] ^ v[W-1] : ovf_q;
    y_vld_d = !rst && bus.ena;
  end
  // output registers
  always_ff @(posedge clk) begin
    y_q     <= y_d;
    err_q   <= err_d;
    ovf_q   <= ovf_d;
    y_vld_q <= y_vld_d;
  end
  assign bus.y     = y_q;
  assign bus.err   = err_q;
  assign bus.ovf   = ovf_q;
  assign bus.y_vld = y_vld_q;
endmodule

// File: tb/tb_csd_to_bin.sv
// tb_csd_to_bin: directed, exhaustive and random checks of csd_to_bin against an arithmetic model
module tb_csd_to_bin;
  localparam int W = 5;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int pass_cnt = 0;
  int total_cnt = 0;
  logic [W-1:0] exp_y = '0;
  logic exp_vld = 1'b0, exp_err = 1'b0, exp_ovf = 1'b0;

  csd_to_bin_if #(.W(W)) bus();
  csd_to_bin #(.W(W)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) $display("FAIL %s got %0h expected %0h", tag, got, exp);
    else pass_cnt++;
  endtask

  function automatic void model(input logic [2*W-1:0] xx, output logic [W-1:0] my,
                                output logic me, output logic mo);
    int v = 0;
    logic [W-1:0] nz = '0;
    me = 1'b0;
    for (int i = 0; i < W; i++) begin
      case (xx[2*i +: 2])
        2'b01: begin v += (1 << i); nz[i] = 1'b1; end
        2'b10: begin v -= (1 << i); nz[i] = 1'b1; end
        2'b11: me = 1'b1;
        default: ;
      endcase
    end
`ifdef CSD_TO_BIN_CANON_CHECK_EN
    for (int i = 0; i < W - 1; i++) if (nz[i] && nz[i+1]) me = 1'b1;
`endif
    my = v[W-1:0];
    mo = (v > (1 << (W - 1)) - 1) || (v < -(1 << (W - 1)));
  endfunction

  task automatic step(input string tag, input logic r, input logic e, input logic [2*W-1:0] xx);
    logic [W-1:0] my;
    logic me, mo;
    @(negedge clk);
    rst = r;
    bus.ena = e;
    bus.x = xx;
    @(posedge clk);
    #1;
    model(xx, my, me, mo);
    if (r) begin
      exp_y = '0; exp_err = 1'b0; exp_ovf = 1'b0; exp_vld = 1'b0;
    end else if (e) begin
      exp_y = my; exp_err = me; exp_ovf = mo; exp_vld = 1'b1;
    end else exp_vld = 1'b0;
    check({tag, ".y"}, 32'(bus.y), 32'(exp_y));
    check({tag, ".vld"}, 32'(bus.y_vld), 32'(exp_vld));
    check({tag, ".err"}, 32'(bus.err), 32'(exp_err));
    check({tag, ".ovf"}, 32'(bus.ovf), 32'(exp_ovf));
  endtask

  initial begin
    logic [2*W-1:0] xx;
    bus.ena = 1'b1;
    bus.x = 10'b01_01_01_01_01;
    step("rst0", 1'b1, 1'b1, 10'b01_01_01_01_01);
    step("rst1", 1'b1, 1'b1, 10'b01_01_01_01_01);
    check("rst.y0", 32'(bus.y), 32'd0);
    step("p1", 1'b0, 1'b1, 10'b00_00_00_00_01);
    check("p1.y1", 32'(bus.y), 32'd1);
    step("mix", 1'b0, 1'b1, 10'b01_00_00_00_10);
    check("mix.y15", 32'(bus.y), 32'd15);
    step("neg", 1'b0, 1'b1, 10'b10_00_00_00_00);
    check("neg.y16", 32'(bus.y), 32'd16);
    step("ovf", 1'b0, 1'b1, 10'b01_01_01_01_01);
    check("ovf.set", 32'(bus.ovf), 32'd1);
    step("ill", 1'b0, 1'b1, 10'b00_00_11_00_01);
    check("ill.set", 32'(bus.err), 32'd1);
    step("hold", 1'b0, 1'b0, 10'b10_10_10_10_10);
    check("hold.y1", 32'(bus.y), 32'd1);
    step("mid0", 1'b0, 1'b1, 10'b10_10_00_00_00);
    step("mid1", 1'b1, 1'b1, 10'b01_00_00_00_00);
    for (int k = 0; k < 243; k++) begin
      int t = k;
      for (int i = 0; i < W; i++) begin
        xx[2*i +: 2] = 2'(t % 3);
        t = t / 3;
      end
      step("sweep", 1'b0, 1'b1, xx);
    end
    for (int k = 0; k < 150; k++)
      step("rand", ($urandom_range(15) == 0), ($urandom_range(3) != 0), 10'($urandom));
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
